// File: rtl/datamemory_pipe.sv
// Byte-enabled single-port synchronous data memory for the MEM stage: valid/ready
// request port, 1- or 2-cycle read latency, post-reset clear sweep, range detection.
module datamemory_pipe #(
  parameter int ADDR_BITS      = 12,
  parameter int DATA_W         = 32,
  parameter int READ_LAT       = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         A,
  input  logic                WE,
  input  logic [DATA_W/8-1:0] ByteEN,
  input  logic [DATA_W-1:0]   WD,
  output logic [DATA_W-1:0]   RD,
  output logic                rd_valid,
  output logic                addr_err,
  output logic                busy
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   clr_cnt;
  logic [ADDR_BITS-1:0]   word_idx;
  logic                   in_range;
  logic                   accept;
  logic [DATA_W-1:0]      mem [DEPTH];

  logic                   s1_valid;
  logic                   s1_err;
  logic [DATA_W-1:0]      s1_data;

  assign word_idx = ADDR_BITS'(A >> OFF);
  assign in_range = (A >> (OFF + ADDR_BITS)) == 32'd0;
  // NOTE: reset is synchronous, so a request presented on a reset edge must be
  // masked explicitly; the registered req_ready still holds its pre-reset value there.
  assign accept   = req_valid && req_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      busy      <= CLEAR_ON_RESET;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_BITS'(1);
          if (&clr_cnt) begin
            state     <= RUN;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM; zeroing is the
  // sweep's job. The sweep and request writes never overlap since req_ready=0 in CLEAR.
  always_ff @(posedge clk) begin
    if (!reset && state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && WE && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (ByteEN[i]) mem[word_idx][8*i +: 8] <= WD[8*i +: 8];
      end
    end
  end

  // First read stage doubles as the RAM output register; out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept && !WE;
      s1_err   <= accept && !in_range;
      if (accept && !WE) s1_data <= in_range ? mem[word_idx] : '0;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_valid <= 1'b0;
          addr_err <= 1'b0;
          RD       <= '0;
        end else begin
          rd_valid <= s1_valid;
          addr_err <= s1_err;
          if (s1_valid) RD <= s1_data;
        end
      end
    end else begin : g_lat1
      assign rd_valid = s1_valid;
      assign addr_err = s1_err;
      assign RD       = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_datamemory_pipe.sv
// Bench for datamemory_pipe: two instances (4096 words / latency 1, 64 words / latency 2)
// share one stimulus stream and are compared every cycle against an array-based model.
module tb_datamemory_pipe;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] A;
  logic        WE;
  logic [3:0]  ByteEN;
  logic [31:0] WD;

  logic [NI-1:0] ready_o, busy_o, rdv_o, err_o;
  logic [31:0]   rd_o [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datamemory_pipe #(.ADDR_BITS(12), .DATA_W(32), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_o[0]),
    .A(A), .WE(WE), .ByteEN(ByteEN), .WD(WD), .RD(rd_o[0]),
    .rd_valid(rdv_o[0]), .addr_err(err_o[0]), .busy(busy_o[0]));

  datamemory_pipe #(.ADDR_BITS(6), .DATA_W(32), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready_o[1]),
    .A(A), .WE(WE), .ByteEN(ByteEN), .WD(WD), .RD(rd_o[1]),
    .rd_valid(rdv_o[1]), .addr_err(err_o[1]), .busy(busy_o[1]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          tag;
    bit          v;
    bit          e;
    logic [31:0] d;
  } resp_t;

  int          depth [NI] = '{4096, 64};
  int          abits [NI] = '{12, 6};
  int          lat   [NI] = '{1, 2};
  logic [31:0] mmem  [NI][4096];
  resp_t       hist  [NI][8];
  int          sweep_left [NI];
  logic [31:0] exp_rd [NI];
  bit          exp_v [NI], exp_e [NI], exp_busy [NI], exp_ready [NI];
  bit          rst_edge = 1'b0;
  bit          armed    = 1'b0;
  int          cyc      = 0;

  always @(posedge clk) begin
    int    key;
    int    widx;
    bit    oor;
    resp_t r;
    cyc++;
    rst_edge = (reset === 1'b1);
    if (rst_edge) armed = 1'b1;
    for (int u = 0; u < NI; u++) begin
      if (rst_edge) begin
        sweep_left[u] = depth[u];
        exp_rd[u]     = 32'd0;
        for (int k = 0; k < 8; k++) hist[u][k].tag = -1;
      end else if (sweep_left[u] > 0) begin
        sweep_left[u]--;
        if (sweep_left[u] == 0)
          for (int w = 0; w < depth[u]; w++) mmem[u][w] = 32'd0;
      end else if (req_valid) begin
        oor  = (A >> (2 + abits[u])) != 32'd0;
        widx = int'((A >> 2) & 32'(depth[u] - 1));
        if (WE && !oor)
          for (int i = 0; i < 4; i++)
            if (ByteEN[i]) mmem[u][widx][8*i +: 8] = WD[8*i +: 8];
        r.tag = cyc;
        r.v   = !WE;
        r.e   = oor;
        r.d   = oor ? 32'd0 : mmem[u][widx];
        hist[u][cyc % 8] = r;
      end
      key          = cyc - lat[u] + 1;
      r            = hist[u][key % 8];
      exp_v[u]     = (r.tag == key) && r.v;
      exp_e[u]     = (r.tag == key) && r.e;
      if (exp_v[u]) exp_rd[u] = r.d;
      exp_busy[u]  = sweep_left[u] > 0;
      exp_ready[u] = sweep_left[u] == 0;
    end
  end

  // ---------------- compare + capture ----------------
  logic [31:0] cap     [NI][16];
  int          cap_cyc [NI][16];
  int          cap_n   [NI];
  int          err_n   [NI];

  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < NI; u++) begin
        check($sformatf("u%0d req_ready", u), 32'(ready_o[u]), 32'(exp_ready[u]));
        check($sformatf("u%0d busy", u),      32'(busy_o[u]),  32'(exp_busy[u]));
        check($sformatf("u%0d rd_valid", u),  32'(rdv_o[u]),   32'(exp_v[u]));
        check($sformatf("u%0d addr_err", u),  32'(err_o[u]),   32'(exp_e[u]));
        if (exp_v[u] || rst_edge)
          check($sformatf("u%0d RD", u), rd_o[u], exp_rd[u]);
        if (rdv_o[u] === 1'b1) begin
          if (cap_n[u] < 16) begin
            cap[u][cap_n[u]]     = rd_o[u];
            cap_cyc[u][cap_n[u]] = cyc;
          end
          cap_n[u]++;
        end
        if (err_o[u] === 1'b1) err_n[u]++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; WE = we; A = a; ByteEN = be; WD = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0; WE = 1'b0; ByteEN = 4'h0;
    end
  endtask

  task automatic clear_caps();
    for (int u = 0; u < NI; u++) begin
      cap_n[u] = 0;
      err_n[u] = 0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(ready_o[0] === 1'b1 && ready_o[1] === 1'b1) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready within budget", 32'(n < 6000), 32'd1);
  endtask

  // Counts cycles u1 stays busy, starting at the negedge right after a reset edge.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_o[1] === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    reset = 1'b1; req_valid = 1'b0; A = '0; WE = 1'b0; ByteEN = '0; WD = '0;
    clear_caps();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_ready();

    // preload word 3, confirm, then pulse reset with a request held during the sweep
    issue(1'b1, 32'hC, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'hC, 4'h0, 32'h0);
    idle(4);
    for (int u = 0; u < NI; u++) check($sformatf("u%0d preload", u), cap[u][0], 32'hDEADBEEF);

    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b1; WE = 1'b1; A = 32'hC; ByteEN = 4'hF; WD = 32'h12345678;
    count_busy(n);
    req_valid = 1'b0;
    check("u1 sweep length", 32'(n), 32'd64);
    wait_ready();
    clear_caps();
    issue(1'b0, 32'hC, 4'h0, 32'h0);
    idle(4);
    for (int u = 0; u < NI; u++) check($sformatf("u%0d word3 cleared", u), cap[u][0], 32'h0);

    // byte lanes + latency
    clear_caps();
    issue(1'b1, 32'h40, 4'hF, 32'h11223344);
    issue(1'b1, 32'h40, 4'h5, 32'hAABBCCDD);
    issue(1'b0, 32'h40, 4'h0, 32'h0);
    acc = cyc + 1;
    idle(4);
    for (int u = 0; u < NI; u++) begin
      check($sformatf("u%0d lanes RD", u), cap[u][0], 32'h11BB33DD);
      check($sformatf("u%0d lanes latency", u), 32'(cap_cyc[u][0]), 32'(acc + lat[u] - 1));
      check($sformatf("u%0d lanes pulses", u), 32'(cap_n[u]), 32'd1);
    end

    // back-to-back reads
    issue(1'b1, 32'h0, 4'hF, 32'd1);
    issue(1'b1, 32'h4, 4'hF, 32'd2);
    issue(1'b1, 32'h8, 4'hF, 32'd3);
    clear_caps();
    issue(1'b0, 32'h0, 4'h0, 32'h0);
    acc = cyc + 1;
    issue(1'b0, 32'h4, 4'h0, 32'h0);
    issue(1'b0, 32'h8, 4'h0, 32'h0);
    idle(5);
    for (int u = 0; u < NI; u++) begin
      check($sformatf("u%0d pipe count", u), 32'(cap_n[u]), 32'd3);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("u%0d pipe RD%0d", u, k), cap[u][k], 32'(k + 1));
        check($sformatf("u%0d pipe cycle%0d", u, k), 32'(cap_cyc[u][k]),
              32'(acc + lat[u] - 1 + k));
      end
    end

    // out of range
    clear_caps();
    issue(1'b1, 32'h4000, 4'hF, 32'hFFFFFFFF);
    issue(1'b0, 32'h4000, 4'h0, 32'h0);
    issue(1'b0, 32'h0000, 4'h0, 32'h0);
    idle(5);
    for (int u = 0; u < NI; u++) begin
      check($sformatf("u%0d oor err pulses", u), 32'(err_n[u]), 32'd2);
      check($sformatf("u%0d oor read pulses", u), 32'(cap_n[u]), 32'd2);
      check($sformatf("u%0d oor RD", u), cap[u][0], 32'h0);
      check($sformatf("u%0d word0 intact", u), cap[u][1], 32'd1);
    end

    // read-after-write
    clear_caps();
    issue(1'b1, 32'h8, 4'hF, 32'hCAFEF00D);
    issue(1'b0, 32'h8, 4'h0, 32'h0);
    idle(4);
    for (int u = 0; u < NI; u++) check($sformatf("u%0d raw RD", u), cap[u][0], 32'hCAFEF00D);

    // reset while a read is in flight
    clear_caps();
    issue(1'b0, 32'h8, 4'h0, 32'h0);
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_busy(n);
    check("u1 restart sweep length", 32'(n), 32'd64);
    check("u1 no rd_valid after reset", 32'(cap_n[1]), 32'd0);
    wait_ready();
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
